uart_fifo_core: RTL and testbench
=================================

// Module: uart_fifo_core
// PURPOSE
//  Next-generation register-mapped UART: 16x-oversampled TX/RX engines behind a byte-wide
//  address/we/re bus, with parametrised TX/RX FIFOs, configurable frame (data bits, parity,
//  stop bits), internal loopback and a maskable level interrupt. Replaces uart_top_design.
// PARAMETERS
//  DATA_BITS   8   frame data width, 5..8; bus bits above DATA_BITS ignored on write, read as 0
//  FIFO_DEPTH  16  entries per FIFO, power of 2, >=2
//  OVERSAMPLE  16  baud ticks per bit (fixed 16 in this revision; parameter reserved)
// PORTS
//  clk         in   1  single clock
//  rst         in   1  synchronous, active-high reset
//  address     in   3  register select
//  write_data  in   8  write bus
//  we          in   1  write strobe, one access per cycle it is high
//  re          in   1  read strobe
//  read_data   out  8  registered read data, valid the cycle after re
//  tx          out  1  serial out, idle high
//  rx          in   1  serial in, asynchronous
//  irq         out  1  registered interrupt, active high
// BEHAVIOUR
//  Map: 0 BAUD_LO, 1 BAUD_HI (16-bit divider), 2 CTRL, 3 DATA (W: push TX FIFO, R: pop RX FIFO),
//   4 STATUS, 5 IRQ_EN, 6-7 unmapped (read 0, writes ignored).
//  CTRL: [0]tx_en [1]rx_en [2]par_en [3]par_odd [4]two_stop [5]loopback.
//  STATUS: [0]tx_empty [1]tx_full [2]rx_empty [3]rx_full [4]tx_busy [5]overrun [6]par_err
//   [7]frame_err; bits 5..7 sticky, cleared by writing 1 (W1C); other bits read-only.
//  Reset: tx=1, read_data=0, irq=0, divider=0, CTRL=0, IRQ_EN=0, FIFOs empty, errors 0.
//  Baud: tick one cycle every DIV clocks (counter reloads DIV-1); DIV=0 stops ticks, engines
//   hold. Divider write resets tick counter. Bit period = 16 ticks.
//  TX FSM IDLE->START->DATA(LSB first, DATA_BITS)->PARITY(if par_en)->STOP(1 or 2)->IDLE;
//   leaves IDLE only when tx_en and TX FIFO non-empty; pops on entering START. Clearing tx_en
//   mid-frame completes current frame. tx_busy=1 outside IDLE.
//  RX: 2-flop synchroniser; loopback selects internal tx instead of rx (tx pin stays driven).
//   RX FSM IDLE->START on low; at tick 8 low confirms start else back to IDLE (glitch reject);
//   DATA/PARITY/STOP sampled at tick 8 of each bit. Parity = even XOR (odd inverts).
//   Stop=0 -> frame_err; parity mismatch -> par_err; byte still pushed. RX FIFO full at push
//   -> byte dropped, overrun=1. After STOP sample return to IDLE (no wait for end of bit).
//  FIFOs: push to full TX FIFO ignored; DATA read when RX empty returns 0, no pop.
//   Simultaneous push+pop when full: both succeed; when empty: push only.
//  Read latency 1: read_data registered from address when re, else holds. RX pop on same edge.
//  Simultaneous W1C and hardware set of same error bit: set wins.
//  irq <= |(STATUS & IRQ_EN) with tx_empty/rx_empty inverted sense replaced by
//   IRQ_EN[0]=tx_empty, [2]=~rx_empty (data available); other bits direct.
//  rst mid-frame: tx to 1 next edge, FSMs to IDLE, FIFOs flushed, partial byte discarded.
// STRUCTURE
//  uart_pkg.vh: register addresses, CTRL/STATUS bit indices, FSM state encodings.
//  Sub-module uart_sync_fifo (WIDTH, DEPTH; push/pop/full/empty/count) instanced twice.
//  Baud tick, TX FSM, RX FSM, register file inline in uart_fifo_core.
// TESTING (clk 50 ns, DIV=130 -> 104000 ns/bit)
//  Reset: after rst, read STATUS -> 0x05, tx=1, irq=0, read_data=0.
//  Loopback 8N1: DIV=130, CTRL=0x23, write DATA 0xB4 -> tx frame 0,00101101,1; rx_empty=0
//   ~1.04 ms later; read DATA -> 0xB4, STATUS errors 0.
//  Burst: push 17 bytes 0x00..0x10 with FIFO_DEPTH=16 -> 17th dropped, 16 bytes received in order.
//  Parity/stop: CTRL par_en|par_odd|two_stop, external rx frame with wrong parity and stop=0
//   -> par_err=1, frame_err=1, byte readable; write 0xC0 to STATUS -> bits 6,7 clear.
//  Overrun: fill RX FIFO (16 frames), send 17th -> overrun=1, FIFO holds first 16.
//  Glitch + mid-frame reset: 3-tick low pulse on rx -> nothing received; rst during DATA ->
//   tx=1 next cycle, FIFOs empty.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared register map, control/status bit positions and FSM state types
// for the register-mapped UART core.
package uart_pkg;

   // Register addresses
   localparam logic [2:0] ADDR_BAUD_LO = 3'd0;
   localparam logic [2:0] ADDR_BAUD_HI = 3'd1;
   localparam logic [2:0] ADDR_CTRL    = 3'd2;
   localparam logic [2:0] ADDR_DATA    = 3'd3;
   localparam logic [2:0] ADDR_STATUS  = 3'd4;
   localparam logic [2:0] ADDR_IRQ_EN  = 3'd5;

   // CTRL bit positions
   localparam int CTRL_TX_EN     = 0;
   localparam int CTRL_RX_EN     = 1;
   localparam int CTRL_PAR_EN    = 2;
   localparam int CTRL_PAR_ODD   = 3;
   localparam int CTRL_TWO_STOP  = 4;
   localparam int CTRL_LOOPBACK  = 5;

   // STATUS bit positions
   localparam int ST_TX_EMPTY  = 0;
   localparam int ST_TX_FULL   = 1;
   localparam int ST_RX_EMPTY  = 2;
   localparam int ST_RX_FULL   = 3;
   localparam int ST_TX_BUSY   = 4;
   localparam int ST_OVERRUN   = 5;
   localparam int ST_PAR_ERR   = 6;
   localparam int ST_FRAME_ERR = 7;

   typedef enum logic [2:0] {
      TX_IDLE,
      TX_START,
      TX_DATA,
      TX_PARITY,
      TX_STOP
   } tx_state_t;

   typedef enum logic [2:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_PARITY,
      RX_STOP
   } rx_state_t;

   // Even parity of a zero-extended data word (zero padding leaves XOR unchanged)
   function automatic logic even_parity(input logic [7:0] d);
      return ^d;
   endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO used for the UART TX and RX queues.
// Push to a full FIFO is ignored unless a pop happens in the same cycle;
// pop from an empty FIFO is ignored.
module uart_sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     push,
   input  logic                     pop,
   input  logic [WIDTH-1:0]         wdata,
   output logic [WIDTH-1:0]         rdata,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   // Qualify requests against current occupancy
   always_comb begin
      full    = (count == CW'(DEPTH));
      empty   = (count == '0);
      do_pop  = pop && !empty;
      do_push = push && (!full || pop);
      rdata   = mem[rd_ptr];
   end

   // Storage array write port
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem[wr_ptr] <= wdata;
      end
   end

   // Pointer and occupancy tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         case ({do_push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_fifo_core.sv
// Register-mapped UART: baud tick generator, 16x-oversampled TX and RX engines,
// TX/RX FIFOs, sticky error flags and a maskable level interrupt.
module uart_fifo_core
   import uart_pkg::*;
#(
   parameter int DATA_BITS  = 8,
   parameter int FIFO_DEPTH = 16,
   parameter int OVERSAMPLE = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] address,
   input  logic [7:0] write_data,
   input  logic       we,
   input  logic       re,
   output logic [7:0] read_data,
   output logic       tx,
   input  logic       rx,
   output logic       irq
);

   localparam logic [3:0] TICK_LAST = 4'(OVERSAMPLE - 1);
   localparam logic [3:0] TICK_MID  = 4'(OVERSAMPLE / 2 - 1);
   localparam logic [2:0] BIT_LAST  = 3'(DATA_BITS - 1);
   localparam int         CW        = $clog2(FIFO_DEPTH) + 1;

   // Register file
   logic [15:0] divisor;
   logic [5:0]  ctrl;
   logic [7:0]  irq_en;
   logic        overrun;
   logic        par_err;
   logic        frame_err;
   logic [7:0]  status;
   logic [7:0]  rd_mux;

   // Bus decode
   logic wr_baud_lo, wr_baud_hi, wr_ctrl, wr_data, wr_status, wr_irq_en, rd_data;

   // Baud generator
   logic [15:0] baud_cnt;
   logic        baud_tick;

   // FIFOs
   logic                 tx_push, tx_pop, tx_full, tx_empty;
   logic [DATA_BITS-1:0] tx_rdata;
   logic [CW-1:0]        tx_count;
   logic                 rx_push, rx_pop, rx_full, rx_empty;
   logic [DATA_BITS-1:0] rx_rdata;
   logic [CW-1:0]        rx_count;
   logic                 unused_counts;

   // TX engine
   tx_state_t            tx_state;
   logic [3:0]           tx_tick_cnt;
   logic [DATA_BITS-1:0] tx_shift;
   logic [2:0]           tx_bit_idx;
   logic                 tx_par_en, tx_parity, tx_two_stop, tx_stop2;
   logic                 tx_bit_end;
   logic                 tx_busy;

   // RX engine
   logic                 rx_meta, rx_sync;
   rx_state_t            rx_state;
   logic [3:0]           rx_tick_cnt;
   logic [DATA_BITS-1:0] rx_shift;
   logic [2:0]           rx_bit_idx;
   logic                 rx_par_en, rx_par_odd, rx_par_bit;
   logic                 rx_sample, rx_bit_end, rx_done;
   logic                 overrun_set, par_err_set, frame_err_set;

   // Address decode and FIFO handshakes
   always_comb begin
      wr_baud_lo = we && (address == ADDR_BAUD_LO);
      wr_baud_hi = we && (address == ADDR_BAUD_HI);
      wr_ctrl    = we && (address == ADDR_CTRL);
      wr_data    = we && (address == ADDR_DATA);
      wr_status  = we && (address == ADDR_STATUS);
      wr_irq_en  = we && (address == ADDR_IRQ_EN);
      rd_data    = re && (address == ADDR_DATA);
      tx_push    = wr_data;
      tx_pop     = (tx_state == TX_IDLE) && ctrl[CTRL_TX_EN] && !tx_empty;
      rx_pop     = rd_data;
      unused_counts = ^{tx_count, rx_count};
   end

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (tx_push),
      .pop   (tx_pop),
      .wdata (write_data[DATA_BITS-1:0]),
      .rdata (tx_rdata),
      .full  (tx_full),
      .empty (tx_empty),
      .count (tx_count)
   );

   uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (rx_push),
      .pop   (rx_pop),
      .wdata (rx_shift),
      .rdata (rx_rdata),
      .full  (rx_full),
      .empty (rx_empty),
      .count (rx_count)
   );

   // One-cycle baud tick every 'divisor' clocks; divisor 0 freezes both engines
   always_comb baud_tick = (divisor != '0) && (baud_cnt == '0);

   // Baud counter counts down and reloads divisor-1; any divisor write restarts it
   always_ff @(posedge clk) begin
      if (rst) begin
         baud_cnt <= '0;
      end else if (wr_baud_lo || wr_baud_hi) begin
         baud_cnt <= '0;
      end else if (divisor == '0) begin
         baud_cnt <= baud_cnt;
      end else if (baud_cnt == '0) begin
         baud_cnt <= divisor - 16'd1;
      end else begin
         baud_cnt <= baud_cnt - 16'd1;
      end
   end

   always_comb tx_bit_end = baud_tick && (tx_tick_cnt == TICK_LAST);
   always_comb tx_busy    = (tx_state != TX_IDLE);

   // TX frame sequencer with registered serial output; frame format latched at pop
   always_ff @(posedge clk) begin
      if (rst) begin
         tx_state    <= TX_IDLE;
         tx          <= 1'b1;
         tx_tick_cnt <= '0;
         tx_shift    <= '0;
         tx_bit_idx  <= '0;
         tx_par_en   <= 1'b0;
         tx_parity   <= 1'b0;
         tx_two_stop <= 1'b0;
         tx_stop2    <= 1'b0;
      end else begin
         if (baud_tick) tx_tick_cnt <= tx_tick_cnt + 4'd1;
         case (tx_state)
            TX_IDLE: begin
               tx          <= 1'b1;
               tx_tick_cnt <= '0;
               if (tx_pop) begin
                  tx_state    <= TX_START;
                  tx          <= 1'b0;
                  tx_shift    <= tx_rdata;
                  tx_bit_idx  <= '0;
                  tx_par_en   <= ctrl[CTRL_PAR_EN];
                  tx_parity   <= even_parity(8'(tx_rdata)) ^ ctrl[CTRL_PAR_ODD];
                  tx_two_stop <= ctrl[CTRL_TWO_STOP];
                  tx_stop2    <= 1'b0;
               end
            end
            TX_START: begin
               if (tx_bit_end) begin
                  tx_state <= TX_DATA;
                  tx       <= tx_shift[0];
               end
            end
            TX_DATA: begin
               if (tx_bit_end) begin
                  if (tx_bit_idx == BIT_LAST) begin
                     if (tx_par_en) begin
                        tx_state <= TX_PARITY;
                        tx       <= tx_parity;
                     end else begin
                        tx_state <= TX_STOP;
                        tx       <= 1'b1;
                     end
                  end else begin
                     tx_bit_idx <= tx_bit_idx + 3'd1;
                     tx_shift   <= {1'b0, tx_shift[DATA_BITS-1:1]};
                     tx         <= tx_shift[1];
                  end
               end
            end
            TX_PARITY: begin
               if (tx_bit_end) begin
                  tx_state <= TX_STOP;
                  tx       <= 1'b1;
               end
            end
            TX_STOP: begin
               tx <= 1'b1;
               if (tx_bit_end) begin
                  if (tx_two_stop && !tx_stop2) begin
                     tx_stop2 <= 1'b1;
                  end else begin
                     tx_state <= TX_IDLE;
                  end
               end
            end
            default: begin
               tx_state <= TX_IDLE;
               tx       <= 1'b1;
            end
         endcase
      end
   end

   // Two-flop synchroniser; loopback feeds the internal tx in place of the rx pin
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_sync <= 1'b1;
      end else begin
         rx_meta <= ctrl[CTRL_LOOPBACK] ? tx : rx;
         rx_sync <= rx_meta;
      end
   end

   // RX strobes: mid-bit sample, end of bit, and frame completion at the stop sample
   always_comb begin
      rx_sample     = baud_tick && (rx_tick_cnt == TICK_MID);
      rx_bit_end    = baud_tick && (rx_tick_cnt == TICK_LAST);
      rx_done       = (rx_state == RX_STOP) && rx_sample;
      rx_push       = rx_done;
      overrun_set   = rx_done && rx_full && !rx_pop;
      frame_err_set = rx_done && !rx_sync;
      par_err_set   = rx_done && rx_par_en &&
                      (rx_par_bit != (even_parity(8'(rx_shift)) ^ rx_par_odd));
   end

   // RX frame sequencer: start confirmation at mid-bit rejects short glitches
   always_ff @(posedge clk) begin
      if (rst) begin
         rx_state    <= RX_IDLE;
         rx_tick_cnt <= '0;
         rx_shift    <= '0;
         rx_bit_idx  <= '0;
         rx_par_en   <= 1'b0;
         rx_par_odd  <= 1'b0;
         rx_par_bit  <= 1'b0;
      end else begin
         if (baud_tick) rx_tick_cnt <= rx_tick_cnt + 4'd1;
         case (rx_state)
            RX_IDLE: begin
               rx_tick_cnt <= '0;
               if (ctrl[CTRL_RX_EN] && !rx_sync) begin
                  rx_state   <= RX_START;
                  rx_par_en  <= ctrl[CTRL_PAR_EN];
                  rx_par_odd <= ctrl[CTRL_PAR_ODD];
               end
            end
            RX_START: begin
               if (rx_sample && rx_sync) begin
                  rx_state <= RX_IDLE;
               end else if (rx_bit_end) begin
                  rx_state   <= RX_DATA;
                  rx_bit_idx <= '0;
               end
            end
            RX_DATA: begin
               if (rx_sample) rx_shift <= {rx_sync, rx_shift[DATA_BITS-1:1]};
               if (rx_bit_end) begin
                  if (rx_bit_idx == BIT_LAST) begin
                     rx_state <= rx_par_en ? RX_PARITY : RX_STOP;
                  end else begin
                     rx_bit_idx <= rx_bit_idx + 3'd1;
                  end
               end
            end
            RX_PARITY: begin
               if (rx_sample)  rx_par_bit <= rx_sync;
               if (rx_bit_end) rx_state   <= RX_STOP;
            end
            RX_STOP: begin
               if (rx_sample) rx_state <= RX_IDLE;
            end
            default: rx_state <= RX_IDLE;
         endcase
      end
   end

   // Writable configuration registers
   always_ff @(posedge clk) begin
      if (rst) begin
         divisor <= '0;
         ctrl    <= '0;
         irq_en  <= '0;
      end else begin
         if (wr_baud_lo) divisor[7:0]  <= write_data;
         if (wr_baud_hi) divisor[15:8] <= write_data;
         if (wr_ctrl)    ctrl          <= write_data[5:0];
         if (wr_irq_en)  irq_en        <= write_data;
      end
   end

   // Sticky error flags: write-1-to-clear, a same-cycle hardware set takes priority
   always_ff @(posedge clk) begin
      if (rst) begin
         overrun   <= 1'b0;
         par_err   <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         overrun   <= overrun_set   | (overrun   & ~(wr_status & write_data[ST_OVERRUN]));
         par_err   <= par_err_set   | (par_err   & ~(wr_status & write_data[ST_PAR_ERR]));
         frame_err <= frame_err_set | (frame_err & ~(wr_status & write_data[ST_FRAME_ERR]));
      end
   end

   // STATUS assembly and read mux
   always_comb begin
      status               = '0;
      status[ST_TX_EMPTY]  = tx_empty;
      status[ST_TX_FULL]   = tx_full;
      status[ST_RX_EMPTY]  = rx_empty;
      status[ST_RX_FULL]   = rx_full;
      status[ST_TX_BUSY]   = tx_busy;
      status[ST_OVERRUN]   = overrun;
      status[ST_PAR_ERR]   = par_err;
      status[ST_FRAME_ERR] = frame_err;
      case (address)
         ADDR_BAUD_LO: rd_mux = divisor[7:0];
         ADDR_BAUD_HI: rd_mux = divisor[15:8];
         ADDR_CTRL:    rd_mux = {2'b00, ctrl};
         ADDR_DATA:    rd_mux = rx_empty ? 8'h00 : 8'(rx_rdata);
         ADDR_STATUS:  rd_mux = status;
         ADDR_IRQ_EN:  rd_mux = irq_en;
         default:      rd_mux = 8'h00;
      endcase
   end

   // Registered read data, held between reads
   always_ff @(posedge clk) begin
      if (rst) begin
         read_data <= '0;
      end else if (re) begin
         read_data <= rd_mux;
      end
   end

   // Interrupt: rx source is "data available" rather than rx_empty
   always_ff @(posedge clk) begin
      if (rst) begin
         irq <= 1'b0;
      end else begin
         irq <= |({status[7:3], ~rx_empty, status[1:0]} & irq_en);
      end
   end

endmodule

// File: tb/tb_uart_fifo_core.sv
// Randomized self-checking bench for uart_fifo_core with a queue-based reference model.
module tb_uart_fifo_core;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] address;
   logic [7:0] write_data;
   logic       we;
   logic       re;
   logic [7:0] read_data;
   logic       tx;
   logic       rx;
   logic       irq;

   int unsigned total;
   int unsigned bad;
   int          div;
   int          bp;

   uart_fifo_core #(.DATA_BITS(8), .FIFO_DEPTH(DEPTH), .OVERSAMPLE(16)) dut (
      .clk        (clk),
      .rst        (rst),
      .address    (address),
      .write_data (write_data),
      .we         (we),
      .re         (re),
      .read_data  (read_data),
      .tx         (tx),
      .rx         (rx),
      .irq        (irq)
   );

   always #25 clk = ~clk;

   task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
      end
   endtask

   task automatic reg_write(input logic [2:0] a, input logic [7:0] d);
      @(negedge clk);
      address = a; write_data = d; we = 1'b1;
      @(negedge clk);
      we = 1'b0;
   endtask

   task automatic reg_read(input logic [2:0] a, output logic [7:0] d);
      @(negedge clk);
      address = a; re = 1'b1;
      @(negedge clk);
      re = 1'b0;
      d = read_data;
   endtask

   task automatic setup(input logic [7:0] ctrl_val);
      reg_write(3'd0, 8'(div));
      reg_write(3'd1, 8'h00);
      reg_write(3'd2, ctrl_val);
   endtask

   // Poll STATUS until (STATUS & mask) == val or the cycle budget runs out
   task automatic wait_status(input string tag, input logic [7:0] mask, input logic [7:0] val,
                              input int budget);
      logic [7:0] s;
      bit ok = 0;
      for (int i = 0; i < budget; i += 2) begin
         reg_read(3'd4, s);
         if ((s & mask) == val) begin
            ok = 1;
            break;
         end
      end
      check_value({tag, "_wait"}, 32'(ok), 32'd1);
   endtask

   task automatic idle_cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // Drive one serial frame on rx; a low stop bit is cut short so no false start follows
   task automatic send_frame(input logic [7:0] d, input bit with_par, input bit par_val,
                             input bit stop_val);
      rx = 1'b0;
      idle_cycles(bp);
      for (int i = 0; i < 8; i++) begin
         rx = d[i];
         idle_cycles(bp);
      end
      if (with_par) begin
         rx = par_val;
         idle_cycles(bp);
      end
      rx = stop_val;
      idle_cycles(stop_val ? bp : 12 * div);
      rx = 1'b1;
      idle_cycles(2 * bp);
   endtask

   initial begin
      logic [7:0] rd;
      logic [7:0] b;
      logic [7:0] exp_q[$];
      bit         exp_ovr;
      bit         pe, po, ts;
      logic       bits[$];
      bit         seen;

      total = 0; bad = 0;
      rst = 1'b1; address = '0; write_data = '0; we = 1'b0; re = 1'b0; rx = 1'b1;
      div = $urandom_range(2, 4);
      bp  = 16 * div;

      // Reset state
      idle_cycles(3);
      check_value("rst_tx", 32'(tx), 32'd1);
      check_value("rst_irq", 32'(irq), 32'd0);
      check_value("rst_rdata", 32'(read_data), 32'd0);
      rst = 1'b0;
      reg_read(3'd4, rd);
      check_value("rst_status", 32'(rd), 32'h05);
      reg_read(3'd2, rd);
      check_value("rst_ctrl", 32'(rd), 32'h00);
      reg_read(3'd6, rd);
      check_value("unmapped_rd", 32'(rd), 32'h00);

      // Loopback frames with random format; waveform checked at mid-bit
      reg_write(3'd5, 8'h04);
      for (int t = 0; t < 4; t++) begin
         pe = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         po = 1'($urandom_range(0, 1));
         ts = (t == 0) ? 1'b0 : 1'($urandom_range(0, 1));
         b  = (t == 0) ? 8'hB4 : 8'($urandom_range(0, 255));
         setup({2'b00, 1'b1, ts, po, pe, 1'b1, 1'b1});
         bits.delete();
         bits.push_back(1'b0);
         for (int i = 0; i < 8; i++) bits.push_back(b[i]);
         if (pe) bits.push_back((^b) ^ po);
         bits.push_back(1'b1);
         if (ts) bits.push_back(1'b1);
         reg_write(3'd3, b);
         seen = 0;
         for (int i = 0; i < 50; i++) begin
            if (tx == 1'b0) begin
               seen = 1;
               break;
            end
            @(negedge clk);
         end
         check_value("lb_start_seen", 32'(seen), 32'd1);
         idle_cycles(bp / 2);
         foreach (bits[k]) begin
            if (k != 0) idle_cycles(bp);
            check_value($sformatf("lb_txbit_%0d_%0d", t, k), 32'(tx), 32'(bits[k]));
         end
         wait_status("lb_rx", 8'h04, 8'h00, 4 * bp);
         check_value("lb_irq_set", 32'(irq), 32'd1);
         reg_read(3'd4, rd);
         check_value("lb_status", 32'(rd & 8'hE4), 32'h00);
         reg_read(3'd3, rd);
         check_value("lb_data", 32'(rd), 32'(b));
         idle_cycles(2);
         check_value("lb_irq_clr", 32'(irq), 32'd0);
         idle_cycles(2 * bp);
      end
      reg_write(3'd5, 8'h00);

      // Burst: fill TX FIFO with transmitter disabled, extra byte dropped
      setup(8'h22);
      exp_q.delete();
      for (int i = 0; i <= DEPTH; i++) begin
         reg_write(3'd3, 8'(i));
         if (exp_q.size() < DEPTH) exp_q.push_back(8'(i));
      end
      reg_read(3'd4, rd);
      check_value("burst_txfull", 32'(rd), 32'h06);
      reg_write(3'd2, 8'h23);
      wait_status("burst_rxfull", 8'h08, 8'h08, (DEPTH + 1) * 11 * bp);
      idle_cycles(12 * bp);
      reg_read(3'd4, rd);
      check_value("burst_status", 32'(rd), 32'h09);
      while (exp_q.size() > 0) begin
         reg_read(3'd3, rd);
         check_value("burst_data", 32'(rd), 32'(exp_q.pop_front()));
      end
      reg_read(3'd3, rd);
      check_value("empty_read", 32'(rd), 32'h00);

      // Parity and stop errors from an external frame, then W1C
      setup(8'h1E);
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, ~((^b) ^ 1'b1), 1'b0);
      wait_status("perr_rx", 8'h04, 8'h00, 2 * bp);
      reg_read(3'd4, rd);
      check_value("perr_status", 32'(rd), 32'hC1);
      reg_read(3'd3, rd);
      check_value("perr_data", 32'(rd), 32'(b));
      reg_write(3'd4, 8'hC0);
      reg_read(3'd4, rd);
      check_value("perr_w1c", 32'(rd), 32'h05);
      b = 8'($urandom_range(0, 255));
      send_frame(b, 1'b1, (^b) ^ 1'b1, 1'b1);
      wait_status("pok_rx", 8'h04, 8'h00, 2 * bp);
      reg_read(3'd4, rd);
      check_value("pok_status", 32'(rd), 32'h01);
      reg_read(3'd3, rd);
      check_value("pok_data", 32'(rd), 32'(b));

      // Overrun: 17 external 8N1 frames into a 16-entry RX FIFO
      setup(8'h02);
      exp_q.delete();
      exp_ovr = 0;
      for (int i = 0; i <= DEPTH; i++) begin
         b = 8'($urandom_range(0, 255));
         send_frame(b, 1'b0, 1'b0, 1'b1);
         if (exp_q.size() < DEPTH) exp_q.push_back(b);
         else exp_ovr = 1;
      end
      reg_read(3'd4, rd);
      check_value("ovr_status", 32'(rd), exp_ovr ? 32'h29 : 32'h09);
      while (exp_q.size() > 0) begin
         reg_read(3'd3, rd);
         check_value("ovr_data", 32'(rd), 32'(exp_q.pop_front()));
      end
      reg_write(3'd4, 8'h20);
      reg_read(3'd4, rd);
      check_value("ovr_w1c", 32'(rd), 32'h05);

      // Glitch: 3-tick low pulse must not start a frame
      rx = 1'b0;
      idle_cycles(3 * div);
      rx = 1'b1;
      idle_cycles(12 * bp);
      reg_read(3'd4, rd);
      check_value("glitch_status", 32'(rd), 32'h05);

      // Reset in the middle of a loopback frame
      setup(8'h23);
      reg_write(3'd3, 8'h5A);
      reg_write(3'd3, 8'hA5);
      idle_cycles(4 * bp);
      rst = 1'b1;
      @(negedge clk);
      check_value("mid_rst_tx", 32'(tx), 32'd1);
      rst = 1'b0;
      reg_read(3'd4, rd);
      check_value("mid_rst_status", 32'(rd), 32'h05);
      idle_cycles(12 * bp);
      reg_read(3'd4, rd);
      check_value("mid_rst_quiet", 32'(rd), 32'h05);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
